// File: rtl/fifo_rd_pkg.sv
// Shared constants and state encoding for the FIFO read-side drain engine.
package fifo_rd_pkg;

   localparam int BUF_DEPTH = 2;

   // Encoding equals the number of buffered words, so the state doubles as occupancy.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry head/skid output buffer with an occupancy FSM; head feeds the stream directly.
module stream_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  ready,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   output logic [1:0]            state
);

   // Handshake: a word moves on a rising edge where valid=1 and ready=1; valid and
   // data depend only on registers and hold steady while valid=1 and ready=0.

   state_t                cur;
   state_t                nxt;
   logic [DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] skid;
   logic                  pop_out;

   assign pop_out = (cur != S_EMPTY) & ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur <= S_EMPTY;
      end else begin
         cur <= nxt;
      end
   end

   always_comb begin
      nxt = cur;
      if (flush) begin
         nxt = S_EMPTY;
      end else begin
         case (cur)
            S_EMPTY: if (wr_en) nxt = S_ONE;
            S_ONE: begin
               if (wr_en && !pop_out)      nxt = S_TWO;
               else if (!wr_en && pop_out) nxt = S_EMPTY;
            end
            S_TWO:   if (pop_out && !wr_en) nxt = S_ONE;
            default: nxt = S_EMPTY;
         endcase
      end
   end

   always_comb begin
      valid = (cur != S_EMPTY);
      data  = head;
      state = cur;
   end

   // An arriving word lands in the head only when the head is free after this cycle's pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         skid <= '0;
      end else if (!flush) begin
         if (cur == S_TWO && pop_out) begin
            head <= skid;
            if (wr_en) skid <= wr_data;
         end else if (wr_en) begin
            if (cur == S_EMPTY || (cur == S_ONE && pop_out)) head <= wr_data;
            else                                              skid <= wr_data;
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(cur == S_TWO && wr_en && !pop_out && !flush));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: pops the async FIFO under a buffer credit and streams words out.
module fifo_rd_stream
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   output logic                  fifo_rd_en_o,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
   input  logic                  flush_i,
   output logic                  m_valid_o,
   output logic [DATA_WIDTH-1:0] m_data_o,
   input  logic                  m_ready_i,
   output logic [1:0]            occupancy_o
);

   logic       infl;
   logic       pop_in;
   logic       pop_out;
   logic       credit_ok;
   logic [1:0] occ;

   assign pop_out = m_valid_o & m_ready_i;

   // Pop only if the word arriving next cycle is guaranteed a free buffer slot.
   always_comb begin
      credit_ok    = ({1'b0, occ} + {2'b00, infl}) < (3'(BUF_DEPTH) + {2'b00, pop_out});
      fifo_rd_en_o = rst_n_i & ~fifo_empty_i & ~flush_i & credit_ok;
   end

   assign pop_in = fifo_rd_en_o & ~fifo_empty_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         infl <= 1'b0;
      end else begin
         infl <= pop_in;
      end
   end

   stream_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk     (clk_i),
      .rst_n   (rst_n_i),
      .flush   (flush_i),
      .wr_en   (infl),
      .wr_data (fifo_rd_data_i),
      .ready   (m_ready_i),
      .valid   (m_valid_o),
      .data    (m_data_o),
      .state   (occ)
   );

   assign occupancy_o = occ;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT, a scoreboard checks the stream.
module tb_fifo_rd_stream;

   localparam int W = 16;

   logic         clk_i = 1'b0;
   logic         rst_n_i = 1'b0;
   logic         fifo_empty_i = 1'b1;
   logic [W-1:0] fifo_rd_data_i = '0;
   logic         flush_i = 1'b0;
   logic         m_ready_i = 1'b0;
   logic         fifo_rd_en_o;
   logic         m_valid_o;
   logic [W-1:0] m_data_o;
   logic [1:0]   occupancy_o;

   logic [W-1:0] fifo_q[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] pop_w;
   logic         gap = 1'b0;
   int           total = 0;
   int           bad = 0;
   int           pops = 0;
   int           xfers = 0;

   logic         pv = 1'b0;
   logic         pr = 1'b0;
   logic         pf = 1'b0;
   logic [W-1:0] pd = '0;

   fifo_rd_stream #(.DATA_WIDTH(W)) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .fifo_rd_en_o   (fifo_rd_en_o),
      .fifo_empty_i   (fifo_empty_i),
      .fifo_rd_data_i (fifo_rd_data_i),
      .flush_i        (flush_i),
      .m_valid_o      (m_valid_o),
      .m_data_o       (m_data_o),
      .m_ready_i      (m_ready_i),
      .occupancy_o    (occupancy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // FIFO model: registered read data, one cycle after an accepted pop.
   always @(posedge clk_i) begin
      if (rst_n_i && fifo_rd_en_o && !fifo_empty_i && fifo_q.size() > 0) begin
         pop_w = fifo_q.pop_front();
         fifo_rd_data_i <= pop_w;
         exp_q.push_back(pop_w);
         pops++;
      end
   end

   // Monitor: scoreboard on transfers, plus per-cycle protocol checks.
   always @(negedge clk_i) begin
      if (!rst_n_i) begin
         pv = 1'b0;
      end else begin
         if (m_valid_o && m_ready_i) begin
            xfers++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_xfer: got %0h expected nothing", m_data_o);
            end else begin
               chk("stream_data", m_data_o, exp_q.pop_front());
            end
         end
         chk("no_pop_when_empty", fifo_rd_en_o & fifo_empty_i, 0);
         chk("occ_max", (occupancy_o > 2'd2), 0);
         if (flush_i) begin
            chk("no_pop_in_flush", fifo_rd_en_o, 0);
            exp_q.delete();
         end
         if (pv && !pr && !pf) begin
            chk("hold_valid", m_valid_o, 1);
            chk("hold_data", m_data_o, pd);
         end
         pv = m_valid_o;
         pr = m_ready_i;
         pd = m_data_o;
         pf = flush_i;
      end
   end

   task automatic upd();
      fifo_empty_i = gap || (fifo_q.size() == 0);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      upd();
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!m_valid_o && n < 20) begin
         tick();
         n++;
      end
      chk(name, m_valid_o, 1);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0 || m_valid_o) && n < 200) begin
         tick();
         n++;
      end
      chk(name, (n < 200), 1);
   endtask

   // Expects rst_n_i low on entry; releases it and checks the first three words.
   task automatic reset_release();
      fifo_q.delete();
      exp_q.delete();
      m_ready_i = 1'b1;
      flush_i = 1'b0;
      gap = 1'b0;
      for (int i = 1; i <= 3; i++) fifo_q.push_back(W'(i));
      upd();
      tick();
      tick();
      chk("rst_rd_en", fifo_rd_en_o, 0);
      chk("rst_valid", m_valid_o, 0);
      chk("rst_data", m_data_o, 0);
      chk("rst_occ", occupancy_o, 0);
      rst_n_i = 1'b1;
      tick();
      chk("s1_valid_c1", m_valid_o, 0);
      tick();
      chk("s1_valid_c2", m_valid_o, 1);
      chk("s1_word1", m_data_o, 16'h0001);
      tick();
      chk("s1_word2", m_data_o, 16'h0002);
      tick();
      chk("s1_word3", m_data_o, 16'h0003);
      tick();
      chk("s1_valid_end", m_valid_o, 0);
      chk("s1_rd_en_end", fifo_rd_en_o, 0);
      chk("s1_fifo_drained", fifo_q.size(), 0);
   endtask

   initial begin
      int x0;
      int p0;
      int sent;
      logic [W-1:0] nxt;

      // Scenario 1: reset with three words queued.
      reset_release();

      // Scenario 2: 100-word continuous stream.
      for (int i = 0; i < 100; i++) fifo_q.push_back(W'(i));
      upd();
      wait_valid("s2_first_valid");
      x0 = xfers;
      repeat (100) tick();
      chk("s2_gapless_count", xfers - x0, 100);
      drain("s2_drain");

      // Scenario 3: back-pressure with eight words waiting.
      m_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) fifo_q.push_back(W'(16'h3000 + i));
      upd();
      p0 = pops;
      x0 = xfers;
      repeat (10) tick();
      chk("s3_occ", occupancy_o, 2);
      chk("s3_pops", pops - p0, 2);
      chk("s3_head", m_data_o, 16'h3000);
      m_ready_i = 1'b1;
      drain("s3_drain");
      chk("s3_count", xfers - x0, 8);

      // Scenario 4: random ready and FIFO-empty gaps.
      sent = 0;
      x0 = xfers;
      for (int c = 0; c < 60000; c++) begin
         if (sent == 10000 && fifo_q.size() == 0 && exp_q.size() == 0 && !m_valid_o) break;
         m_ready_i = 1'($urandom_range(0, 1));
         gap = ($urandom_range(0, 3) == 0);
         if (sent < 10000 && fifo_q.size() < 4) begin
            fifo_q.push_back(W'($urandom));
            sent++;
         end
         upd();
         tick();
      end
      gap = 1'b0;
      upd();
      chk("s4_count", xfers - x0, 10000);

      // Scenario 5a: flush with the buffer full and the consumer stalled.
      m_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) fifo_q.push_back(W'(16'h5000 + i));
      upd();
      repeat (6) tick();
      chk("s5a_occ_before", occupancy_o, 2);
      flush_i = 1'b1;
      nxt = fifo_q[0];
      tick();
      flush_i = 1'b0;
      chk("s5a_valid", m_valid_o, 0);
      chk("s5a_occ", occupancy_o, 0);
      m_ready_i = 1'b1;
      wait_valid("s5a_refill");
      chk("s5a_next_word", m_data_o, nxt);
      drain("s5a_drain");

      // Scenario 5b: flush mid-stream with a word in flight and a transfer in the same cycle.
      for (int i = 0; i < 8; i++) fifo_q.push_back(W'(16'h6000 + i));
      upd();
      wait_valid("s5b_first_valid");
      tick();
      flush_i = 1'b1;
      nxt = fifo_q[0];
      tick();
      flush_i = 1'b0;
      chk("s5b_valid", m_valid_o, 0);
      chk("s5b_occ", occupancy_o, 0);
      wait_valid("s5b_refill");
      chk("s5b_next_word", m_data_o, nxt);
      drain("s5b_drain");

      // Scenario 6: asynchronous reset while one word is buffered.
      m_ready_i = 1'b0;
      fifo_q.push_back(16'h7777);
      upd();
      repeat (4) tick();
      chk("s6_occ_before", occupancy_o, 1);
      #2;
      rst_n_i = 1'b0;
      #1;
      chk("s6_async_valid", m_valid_o, 0);
      chk("s6_async_occ", occupancy_o, 0);
      chk("s6_async_data", m_data_o, 0);
      chk("s6_async_rd_en", fifo_rd_en_o, 0);
      reset_release();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
